// File: rtl/calc_pkg.sv
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/calc_sched_rr_arb2.sv
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       advance,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (advance) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
  end

endmodule

// File: rtl/calc_sched.sv
module calc_sched
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [2:0]       dp_op,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  input  logic [WIDTH-1:0] dp_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_src,
  output logic             res_err
);

  localparam int unsigned CNT_W = 4;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               src_q, src_d;
  logic [2:0]         dp_op_q, dp_op_d;
  logic [WIDTH-1:0]   dp_a_q, dp_a_d;
  logic [WIDTH-1:0]   dp_b_q, dp_b_d;
  logic [WIDTH-1:0]   res_data_q, res_data_d;
  logic               res_err_q, res_err_d;

  logic [1:0]         grant;
  logic [2:0]         sel_op;
  logic [WIDTH-1:0]   sel_a, sel_b;

  // rst_n gates the grant so ready is 0 while reset is held, not just after it
  rr_arb2 u_arb (
    .valid   ({req1_valid, req0_valid}),
    .ptr     (ptr_q),
    .advance ((state_q == IDLE) && rst_n),
    .grant   (grant)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    dp_op_d    = dp_op_q;
    dp_a_d     = dp_a_q;
    dp_b_d     = dp_b_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    sel_op     = grant[1] ? req1_op : req0_op;
    sel_a      = grant[1] ? req1_a  : req0_a;
    sel_b      = grant[1] ? req1_b  : req0_b;

    case (state_q)
      IDLE: begin
        if (|grant) begin
          src_d = grant[1];
          ptr_d = grant[0];
          if (!op_legal(sel_op) ||
              (((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (sel_b == '0))) begin
            res_err_d  = 1'b1;
            res_data_d = '0;
            state_d    = DONE;
          end else begin
            dp_op_d = sel_op;
            dp_a_d  = sel_a;
            dp_b_d  = sel_b;
            cnt_d   = CNT_W'(LAT - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          res_data_d = dp_out;
          res_err_d  = 1'b0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      cnt_q      <= '0;
      src_q      <= 1'b0;
      dp_op_q    <= '0;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      dp_op_q    <= dp_op_d;
      dp_a_q     <= dp_a_d;
      dp_b_q     <= dp_b_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign dp_op      = dp_op_q;
  assign dp_a       = dp_a_q;
  assign dp_b       = dp_b_q;
  assign res_valid  = (state_q == DONE);
  assign res_data   = res_data_q;
  assign res_src    = src_q;
  assign res_err    = res_err_q;

endmodule

// File: tb/tb_calc_sched.sv
module tb_calc_sched;
  import calc_pkg::*;

  localparam int unsigned W   = 64;
  localparam int unsigned LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]   req0_op, req1_op, dp_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, dp_a, dp_b, dp_out, res_data;
  logic         res_valid, res_ready, res_src, res_err;

  typedef struct packed {
    logic [W-1:0] data;
    logic         src;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  calc_sched #(.WIDTH(W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .dp_op(dp_op), .dp_a(dp_a), .dp_b(dp_b), .dp_out(dp_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_src(res_src), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // arithmetic unit model
  always_comb begin
    dp_out = '0;
    case (dp_op)
      OP_ADD: dp_out = dp_a + dp_b;
      OP_SUB: dp_out = dp_a - dp_b;
      OP_MUL: dp_out = dp_a * dp_b;
      OP_DIV: dp_out = (dp_b == '0) ? '0 : dp_a / dp_b;
      OP_MOD: dp_out = (dp_b == '0) ? '0 : dp_a % dp_b;
      default: dp_out = '0;
    endcase
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // monitor: pops and compares on every result handshake
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0d required=none", res_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_src", {63'd0, res_src}, {63'd0, e.src});
        chk("res_err", {63'd0, res_err}, {63'd0, e.err});
      end
    end
  end

  task automatic do_cmd(input int port, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ed, input logic ee,
                        input int elat, input string nm);
    int n;
    req0_valid = (port == 0);
    req1_valid = (port == 1);
    if (port == 0) begin req0_op = op; req0_a = a; req0_b = b; end
    else           begin req1_op = op; req1_a = a; req1_b = b; end
    @(negedge clk);
    chk({nm, "_grant"}, (port == 0) ? req0_ready : req1_ready, 1);
    chk({nm, "_nogrant_other"}, (port == 0) ? req1_ready : req0_ready, 0);
    sb.push_back('{data: ed, src: port[0], err: ee});
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 0;
    n = 1;
    while (n <= 40) begin
      @(negedge clk);
      if (res_valid) break;
      n++;
    end
    chk({nm, "_latency"}, n, elat);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain"}, sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    int last_g;
    int cyc;
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;

    rst_n = 0; res_ready = 1;
    req0_valid = 1; req0_op = OP_ADD; req0_a = 1; req0_b = 1;
    req1_valid = 1; req1_op = OP_ADD; req1_a = 1; req1_b = 1;
    #3;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    @(posedge clk); @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_dp_op", dp_op, 0);
    chk("rst_dp_a", dp_a, 0);
    chk("rst_dp_b", dp_b, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_res_src", res_src, 0);
    @(posedge clk); #1;

    // single ADD
    do_cmd(0, OP_ADD, 5, 7, 12, 0, LAT + 1, "add");

    // divide by zero on requester 1; datapath untouched
    do_cmd(1, OP_DIV, 100, 0, 0, 1, 1, "div0");
    chk("div0_dp_op", dp_op, OP_ADD);
    chk("div0_dp_a", dp_a, 5);
    chk("div0_dp_b", dp_b, 7);

    // both requesters valid continuously
    req0_op = OP_SUB; req0_a = 10; req0_b = 3;
    req1_op = OP_MUL; req1_a = 6;  req1_b = 7;
    req0_valid = 1; req1_valid = 1;
    grants = 0; last_g = 0; cyc = 0;
    while (grants < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (res_valid) chk("rr_ready_in_done", {req1_ready, req0_ready}, 0);
      if (req0_ready || req1_ready) begin
        chk("rr_grant_order", {req1_ready, req0_ready}, exp_g[grants]);
        if (grants > 0) chk("rr_grant_spacing", cyc - last_g, LAT + 2);
        sb.push_back(req0_ready ? exp_t'{data: 7, src: 0, err: 0}
                                : exp_t'{data: 42, src: 1, err: 0});
        last_g = cyc;
        grants++;
      end
    end
    chk("rr_grant_count", grants, 4);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    drain("rr");
    @(posedge clk); #1;

    // illegal op then MOD
    do_cmd(0, 3'b101, 3, 4, 0, 1, 1, "illegal");
    do_cmd(0, OP_MOD, 17, 5, 2, 0, LAT + 1, "mod");

    // backpressure
    res_ready = 0;
    do_cmd(0, OP_DIV, 81, 9, 9, 0, LAT + 1, "bp");
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_data, 9);
      chk("bp_no_ready", {req1_ready, req0_ready}, 0);
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0; res_ready = 1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_valid_drop", res_valid, 0);
    chk("bp_drain", sb.size(), 0);
    @(posedge clk); #1;

    // reset during WAIT of a MUL
    req0_op = OP_MUL; req0_a = 3; req0_b = 4; req0_valid = 1;
    @(negedge clk);
    chk("rstw_grant", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 1; req0_valid = 1;
    #2 rst_n = 0;
    #1;
    chk("rstw_dp_op", dp_op, 0);
    chk("rstw_dp_a", dp_a, 0);
    chk("rstw_dp_b", dp_b, 0);
    chk("rstw_res_valid", res_valid, 0);
    chk("rstw_ready", {req1_ready, req0_ready}, 0);
    @(posedge clk); @(posedge clk); #1;
    req0_op = OP_ADD; req0_a = 1; req0_b = 1;
    req1_op = OP_SUB; req1_a = 5; req1_b = 1;
    #2 rst_n = 1;
    @(negedge clk);
    chk("rstw_first_grant", {req1_ready, req0_ready}, 2'b01);
    chk("rstw_res_valid_after", res_valid, 0);
    sb.push_back('{data: 2, src: 0, err: 0});
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    drain("rstw");
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
